vecmat_pack_x: RTL and testbench

- Gathers a stream of 16-bit elements, one per handshake, into a full varraysize-bit vector.
- Presents the vector with a valid/ready handshake, ready to drive the data_x / W_x inputs of the vecmat_x blocks in the LSTM datapath.
- It is the producer (writer) side of the wide-vector interface that the vecmat_x units consume.

---
 rtl/vecmat_pkg.sv | 22 ++
 rtl/vecmat_pack_x.sv | 107 ++++++++++
 tb/tb_vecmat_pack_x.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vecmat_pkg.sv
// Shared definitions for the wide-vector packer and the future unpacker:
// element width, FSM state encoding and counter width helpers.
package vecmat_pkg;

  localparam int ELEM_W = 16;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int count_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  // Width of an index that must hold the values 0..n-1.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vecmat_pack_x.sv
// Packs a stream of 16-bit elements into one varraysize-bit vector and
// presents it to the vecmat_x consumers over a valid/ready handshake.
module vecmat_pack_x
  import vecmat_pkg::*;
#(
  parameter int varraysize = 1600,
  parameter int vectwidth  = 100
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           in_valid,
  input  logic [ELEM_W-1:0]              in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [varraysize-1:0]          out_vec,
  output logic [count_w(vectwidth)-1:0]  elem_count,
  output state_t                         state
);

  localparam int IDX_W = idx_w(vectwidth);
  localparam int CNT_W = count_w(vectwidth);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(vectwidth - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Valid never depends on ready; in_ready follows out_ready while
  // FULL so a new element can enter in the same cycle the vector leaves.

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [varraysize-1:0]   vec_q, vec_d;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic                    in_acc, out_acc;

  assign in_ready   = (state_q == FILL) ? 1'b1 : out_ready;
  assign out_valid  = (state_q == FULL);
  assign out_vec    = vec_q;
  assign elem_count = (state_q == FULL) ? CNT_W'(vectwidth) : CNT_W'(idx_q);
  assign state      = state_q;

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    if (clear) begin
      // Abort wins over both handshakes; slot contents are left as they are.
      state_d = FILL;
      idx_d   = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_acc) begin
            wr_en = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = FULL;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (out_acc) begin
            state_d = FILL;
            if (in_acc) begin
              wr_en  = 1'b1;
              wr_idx = '0;
              idx_d  = IDX_W'(1);
            end else begin
              idx_d = '0;
            end
          end
        end
        default: begin
          state_d = FILL;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    vec_d = vec_q;
    if (wr_en) begin
      vec_d[wr_idx*ELEM_W +: ELEM_W] = in_data;
    end
  end

endmodule

// File: tb/tb_vecmat_pack_x.sv
// Directed bench for vecmat_pack_x: an element-level model builds expected
// vectors, which are queued and compared on every output handshake.
module tb_vecmat_pack_x;
  import vecmat_pkg::*;

  localparam int VW  = 100;
  localparam int VS  = 1600;
  localparam int CW  = count_w(VW);

  logic            clk = 1'b0;
  logic            reset;
  logic            clear;
  logic            in_valid;
  logic [15:0]     in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [VS-1:0]   out_vec;
  logic [CW-1:0]   elem_count;
  state_t          state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [VS-1:0] exp_q[$];
  logic [VS-1:0] cur_vec = '0;
  int            cur_k   = 0;

  vecmat_pack_x #(.varraysize(VS), .vectwidth(VW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .elem_count(elem_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VS-1:0] obs, input logic [VS-1:0] exp);
    int bad;
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      bad = 0;
      for (int s = VW - 1; s >= 0; s--)
        if (obs[s*16 +: 16] !== exp[s*16 +: 16]) bad = s;
      $error("FAIL %s: slot %0d observed %0h expected %0h", tag, bad,
             obs[bad*16 +: 16], exp[bad*16 +: 16]);
    end
  endtask

  // Output scoreboard: a handshake is about to happen on the next rising edge.
  always @(negedge clk) begin
    if (reset && !clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_vector", 32'd1, 32'd0);
      end else begin
        chk_vec("out_vec", out_vec, exp_q.pop_front());
      end
    end
  end

  // Present one element until accepted; stalls counts cycles with in_ready low.
  task automatic push_elem(input logic [15:0] d, output int stalls);
    logic acc;
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        cur_vec[cur_k*16 +: 16] = d;
        cur_k++;
        if (cur_k == VW) begin
          exp_q.push_back(cur_vec);
          cur_k = 0;
        end
        in_valid = 1'b0;
        return;
      end
      stalls++;
    end
    chk("push_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int            st;
    int            total_stalls;
    logic [15:0]   d;
    logic [15:0]   elem101;
    logic [VS-1:0] snap;

    reset = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_elem_count", 32'(elem_count), 32'd0);
    chk("rst_state", 32'(state), 32'(FILL));
    chk_vec("rst_out_vec", out_vec, '0);
    reset = 1'b1; in_valid = 1'b0;
    step();

    // Full fill with the consumer stalled.
    for (int i = 1; i <= VW; i++) begin
      push_elem(16'(i), st);
      if (i == VW - 1) chk("valid_before_last", 32'(out_valid), 32'd0);
      if (i == 37) chk("count_mid", 32'(elem_count), 32'd37);
    end
    chk("valid_after_last", 32'(out_valid), 32'd1);
    chk("slot0", 32'(out_vec[15:0]), 32'h0001);
    chk("slot99", 32'(out_vec[1599:1584]), 32'h0064);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(elem_count), 32'd100);

    // Backpressure: inputs offered but must be ignored, vector must hold.
    snap = out_vec;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = 16'($urandom_range(0, 65535));
      step();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_count", 32'(elem_count), 32'd100);
      chk_vec("bp_stable", out_vec, snap);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_state", 32'(state), 32'(FILL));
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_count", 32'(elem_count), 32'd0);

    // Back-to-back: 200 elements with the consumer always ready.
    total_stalls = 0;
    elem101 = '0;
    for (int i = 1; i <= 2 * VW; i++) begin
      d = 16'($urandom_range(0, 65535));
      if (i == VW + 1) elem101 = d;
      push_elem(d, st);
      total_stalls += st;
      if (i == VW + 1) begin
        chk("b2b_count_after_101", 32'(elem_count), 32'd1);
        chk("b2b_state_after_101", 32'(state), 32'(FILL));
      end
    end
    chk("b2b_no_bubble", 32'(total_stalls), 32'd0);
    chk("b2b_second_valid", 32'(out_valid), 32'd1);
    chk("b2b_second_slot0", 32'(out_vec[15:0]), 32'(elem101));
    step();
    chk("b2b_drained", 32'(out_valid), 32'd0);

    // Clear mid-fill: the element offered alongside clear is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 37; i++) push_elem(16'($urandom_range(0, 65535)), st);
    chk("pre_clear_count", 32'(elem_count), 32'd37);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
    step();
    clear = 1'b0; in_valid = 1'b0;
    cur_k = 0;
    chk("clear_count", 32'(elem_count), 32'd0);
    chk("clear_state", 32'(state), 32'(FILL));
    for (int i = 0; i < VW; i++) push_elem(16'(16'h4000 + i), st);
    chk("clear_refill_valid", 32'(out_valid), 32'd1);
    chk("clear_refill_slot0", 32'(out_vec[15:0]), 32'h4000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset while holding a full vector.
    for (int i = 0; i < VW; i++) push_elem(16'($urandom_range(1, 65535)), st);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    void'(exp_q.pop_back());
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_count", 32'(elem_count), 32'd0);
    chk_vec("rst_hold_vec", out_vec, '0);
    step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
